// File: rtl/qubit_pkg.sv
// Shared definitions for the qubit readout path: analysis mode codes and the
// shot sequencer state encoding.
package qubit_pkg;

  localparam logic [1:0] DATA_DUMP_MODE = 2'b00;
  localparam logic [1:0] CLASSIFY_MODE  = 2'b01;
  localparam logic [1:0] HIST2D_MODE    = 2'b11;

  typedef enum logic [2:0] {
    StIdle,
    StArm,
    StWait,
    StDelay,
    StFin
  } seq_state_e;

  function automatic logic mode_legal(input logic [1:0] mode);
    return mode inside {DATA_DUMP_MODE, CLASSIFY_MODE, HIST2D_MODE};
  endfunction

endpackage

// File: rtl/delay_timer.sv
// Loadable down-counter; expired flags the final counted cycle so the owner
// can leave its state exactly when the programmed number of cycles has elapsed.
module delay_timer #(
  parameter int unsigned W = 16
) (
  input  logic         clk100,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         expired
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (en && (count_q != '0)) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clk100) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == W'(1));

endmodule

// File: rtl/shot_sequencer.sv
// Shot sequencer: fires trig once per shot, tallies classifier verdicts and
// spaces shots by rep_delay idle cycles. Define SHOT_TIMEOUT_EN for a WAIT timeout.
module shot_sequencer
  import qubit_pkg::*;
#(
  parameter int unsigned CNT_W          = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic             clk100,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] num_shots,
  input  logic [1:0]       mode_in,
  input  logic [CNT_W-1:0] rep_delay,
  output logic [1:0]       analyze_mode,
  output logic             trig,
  input  logic             sample_valid,
  input  logic             excited,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] shot_count,
  output logic [CNT_W-1:0] excited_count,
  output logic             error
);

  // One timer serves both rep_delay and the timeout, so size it for either.
  localparam int unsigned ToW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned TimerW = (CNT_W > ToW) ? CNT_W : ToW;

  seq_state_e       state_q, state_d;
  logic [CNT_W-1:0] num_q, num_d, rep_q, rep_d;
  logic [CNT_W-1:0] shot_q, shot_d, exc_q, exc_d;
  logic [1:0]       mode_q, mode_d;
  logic             err_q, err_d;
  logic             timer_load, timer_en, timer_expired;
  logic [TimerW-1:0] timer_val;

  delay_timer #(
    .W(TimerW)
  ) u_delay_timer (
    .clk100  (clk100),
    .reset   (reset),
    .load    (timer_load),
    .load_val(timer_val),
    .en      (timer_en),
    .expired (timer_expired)
  );

  always_comb begin
    state_d    = state_q;
    num_d      = num_q;
    rep_d      = rep_q;
    mode_d     = mode_q;
    shot_d     = shot_q;
    exc_d      = exc_q;
    err_d      = err_q;
    timer_load = 1'b0;
    timer_val  = '0;
    timer_en   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (!mode_legal(mode_in)) begin
            err_d = 1'b1;
          end else begin
            num_d   = num_shots;
            rep_d   = rep_delay;
            mode_d  = mode_in;
            shot_d  = '0;
            exc_d   = '0;
            err_d   = 1'b0;
            state_d = (num_shots == '0) ? StFin : StArm;
          end
        end
      end
      StArm: begin
        state_d = StWait;
`ifdef SHOT_TIMEOUT_EN
        timer_load = 1'b1;
        timer_val  = TimerW'(TIMEOUT_CYCLES);
`endif
      end
      StWait: begin
        if (sample_valid) begin
          shot_d = shot_q + CNT_W'(1);
          if (excited) exc_d = exc_q + CNT_W'(1);
          if ((shot_q + CNT_W'(1)) == num_q) begin
            state_d = StFin;
          end else if (rep_q == '0) begin
            state_d = StArm;
          end else begin
            state_d    = StDelay;
            timer_load = 1'b1;
            timer_val  = TimerW'(rep_q);
          end
        end
`ifdef SHOT_TIMEOUT_EN
        else begin
          timer_en = 1'b1;
          if (timer_expired) begin
            err_d   = 1'b1;
            state_d = StFin;
          end
        end
`endif
      end
      StDelay: begin
        timer_en = 1'b1;
        if (timer_expired) state_d = StArm;
      end
      StFin: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk100) begin
    if (reset) begin
      state_q <= StIdle;
      num_q   <= '0;
      rep_q   <= '0;
      mode_q  <= DATA_DUMP_MODE;
      shot_q  <= '0;
      exc_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      num_q   <= num_d;
      rep_q   <= rep_d;
      mode_q  <= mode_d;
      shot_q  <= shot_d;
      exc_q   <= exc_d;
      err_q   <= err_d;
    end
  end

  assign busy          = (state_q != StIdle);
  assign trig          = (state_q == StArm);
  assign done          = (state_q == StFin);
  assign analyze_mode  = busy ? mode_q : DATA_DUMP_MODE;
  assign shot_count    = shot_q;
  assign excited_count = exc_q;
  assign error         = err_q;

endmodule
